// File: rtl/btn_step_gen.sv
// ---------------------------------------------------------------------------
// btn_step_gen
//
// Purpose:
//   Turns two raw push-button levels (east / west) into clean one-cycle step
//   pulses for a position counter. Each raw level is synchronized, then a
//   single FSM debounces the press, emits one pulse in the pressed
//   direction, and debounces the release. Pulses never overlap and never
//   last longer than one cycle.
//
// Optional feature:
//   `define AUTO_REPEAT_EN  -- while a button stays held, emit a further pulse
//   REPEAT_DELAY cycles after the first one, then one every REPEAT_PERIOD
//   cycles. Without the macro only one pulse is emitted per accepted press.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples to accept a press / release
//   REPEAT_DELAY     cycles from first pulse to first auto-repeat pulse
//   REPEAT_PERIOD    cycles between successive auto-repeat pulses
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   asynchronous active-low reset
//   east_raw  in   raw east button level, 1 = pressed
//   west_raw  in   raw west button level, 1 = pressed
//   east      out  registered one-cycle east step pulse
//   west      out  registered one-cycle west step pulse
//   pressed   out  registered debounced level, 1 while a press is held
// ---------------------------------------------------------------------------
module btn_step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic east_raw,
  input  logic west_raw,
  output logic east,
  output logic west,
  output logic pressed
);

`ifdef AUTO_REPEAT_EN
  localparam logic RPT_EN = 1'b1;
`else
  localparam logic RPT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DB_PRESS,
    S_HOLD,
    S_REPEAT,
    S_DB_RELEASE
  } state_t;

  // Synchronizers: bit 0 is the first flop, bit 1 feeds the FSM.
  logic [1:0]  r_sync_e;
  logic [1:0]  r_sync_w;

  state_t      r_state;
  logic [19:0] r_cnt;
  logic        r_dir;       // 0 = east, 1 = west
  logic        r_east;
  logic        r_west;
  logic        r_pressed;

  state_t      w_state_next;
  logic [19:0] w_cnt_next;
  logic        w_dir_next;
  logic        w_pulse;
  logic        w_east_next;
  logic        w_west_next;
  logic        w_pressed_next;

  logic        w_e;
  logic        w_w;
  logic        w_lat_hi;
  logic [19:0] w_cnt_inc;
  logic [31:0] w_cnt_ext;
  logic        w_press_done;
  logic        w_hold_done;
  logic        w_rep_done;
  logic        w_rel_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_e <= 2'b00;
      r_sync_w <= 2'b00;
    end else begin
      r_sync_e <= {r_sync_e[0], east_raw};
      r_sync_w <= {r_sync_w[0], west_raw};
    end
  end

  assign w_e       = r_sync_e[1];
  assign w_w       = r_sync_w[1];
  assign w_lat_hi  = r_dir ? w_w : w_e;
  assign w_cnt_inc = (r_cnt == 20'hFFFFF) ? r_cnt : r_cnt + 20'd1;
  assign w_cnt_ext = {12'd0, r_cnt};

  // In DB_PRESS the IDLE sample already counted as the first high sample,
  // so the current sample is number r_cnt+2.
  assign w_press_done = (w_cnt_ext + 32'd2) >= DEBOUNCE_CYCLES;
  assign w_hold_done  = (w_cnt_ext + 32'd1) >= REPEAT_DELAY;
  assign w_rep_done   = (w_cnt_ext + 32'd1) >= REPEAT_PERIOD;
  assign w_rel_done   = (w_cnt_ext + 32'd1) >= DEBOUNCE_CYCLES;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 20'd0;
      r_dir     <= 1'b0;
      r_east    <= 1'b0;
      r_west    <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_dir     <= w_dir_next;
      r_east    <= w_east_next;
      r_west    <= w_west_next;
      r_pressed <= w_pressed_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir;
    w_pulse      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_e ^ w_w) begin
          w_dir_next = w_w;
          w_cnt_next = 20'd0;
          if (DEBOUNCE_CYCLES <= 32'd1) begin
            w_pulse      = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_state_next = S_DB_PRESS;
          end
        end
      end
      S_DB_PRESS: begin
        if (!w_lat_hi) begin
          w_cnt_next   = 20'd0;
          w_state_next = S_IDLE;
        end else if (w_press_done) begin
          w_pulse      = 1'b1;
          w_cnt_next   = 20'd0;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_HOLD, S_REPEAT: begin
        // Only the latched button matters here; the other one is ignored.
        if (!w_lat_hi) begin
          w_cnt_next   = 20'd0;
          w_state_next = S_DB_RELEASE;
        end else if (RPT_EN && ((r_state == S_HOLD) ? w_hold_done : w_rep_done)) begin
          w_pulse      = 1'b1;
          w_cnt_next   = 20'd0;
          w_state_next = S_REPEAT;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_DB_RELEASE: begin
        if (w_e || w_w) begin
          w_cnt_next = 20'd0;
        end else if (w_rel_done) begin
          w_cnt_next   = 20'd0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_next   = 20'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: one pulse is steered to exactly one direction.
  always_comb begin
    w_east_next    = w_pulse & ~w_dir_next;
    w_west_next    = w_pulse & w_dir_next;
    w_pressed_next = (w_state_next == S_HOLD) || (w_state_next == S_REPEAT) ||
                     (w_state_next == S_DB_RELEASE);
  end

  assign east    = r_east;
  assign west    = r_west;
  assign pressed = r_pressed;

endmodule

// File: tb/tb_btn_step_gen.sv
// ---------------------------------------------------------------------------
// tb_btn_step_gen
//
// Scoreboard bench for btn_step_gen. Every clock edge the stimulus side runs
// a behavioural model (two-sample synchronizer delay, then press / hold /
// release rules expressed as sample run lengths) and queues the expected
// {east, west, pressed}; a monitor on the falling edge pops and compares.
// Directed scenarios add absolute timing checks; a random phase follows.
// ---------------------------------------------------------------------------
module tb_btn_step_gen;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic east_raw = 1'b0;
  logic west_raw = 1'b0;
  logic east;
  logic west;
  logic pressed;

  int n_tests = 0;
  int n_fail  = 0;
  int stepno  = 0;

  logic [2:0] sb[$];

  btn_step_gen #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .east_raw(east_raw),
    .west_raw(west_raw),
    .east    (east),
    .west    (west),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_PRESSING = 1, M_HELD = 2, M_RELEASING = 3;
  int   m_mode;
  int   m_run;        // consecutive high samples while pressing
  int   m_low;        // consecutive all-low samples while releasing
  int   m_since;      // cycles since the last emitted pulse while held
  bit   m_repeating;
  logic m_dir;        // 1 = west
  logic m_s1e, m_s1w, m_s2e, m_s2w;
  logic m_east, m_west, m_pressed;

  function void model_reset();
    m_mode = M_IDLE; m_run = 0; m_low = 0; m_since = 0; m_repeating = 0;
    m_dir = 0; m_s1e = 0; m_s1w = 0; m_s2e = 0; m_s2w = 0;
    m_east = 0; m_west = 0; m_pressed = 0;
  endfunction

  function void model_edge(input logic e_raw, input logic w_raw);
    logic se, sw, mine, pulse;
    se = m_s2e; sw = m_s2w;
    m_s2e = m_s1e; m_s2w = m_s1w;
    m_s1e = e_raw; m_s1w = w_raw;
    pulse = 0;
    mine = m_dir ? sw : se;
    case (m_mode)
      M_IDLE: if (se != sw) begin
        m_dir = sw; m_run = 1;
        if (m_run >= DC) begin pulse = 1; m_mode = M_HELD; m_since = 0; m_repeating = 0; end
        else m_mode = M_PRESSING;
      end
      M_PRESSING: if (mine) begin
        m_run++;
        if (m_run >= DC) begin pulse = 1; m_mode = M_HELD; m_since = 0; m_repeating = 0; end
      end else m_mode = M_IDLE;
      M_HELD: if (!mine) begin
        m_mode = M_RELEASING; m_low = 0;
      end else if (AUTO) begin
        m_since++;
        if (m_since >= (m_repeating ? RP : RD)) begin
          pulse = 1; m_since = 0; m_repeating = 1;
        end
      end
      default: if (se || sw) m_low = 0;
      else begin
        m_low++;
        if (m_low >= DC) m_mode = M_IDLE;
      end
    endcase
    m_east    = pulse && !m_dir;
    m_west    = pulse && m_dir;
    m_pressed = (m_mode == M_HELD) || (m_mode == M_RELEASING);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [2:0] exp_v;
      exp_v = sb.pop_front();
      n_tests++;
      if ({east, west, pressed} !== exp_v) begin
        n_fail++;
        $display("FAIL outputs step=%0d east/west/pressed got=%b%b%b expected=%b",
                 stepno, east, west, pressed, exp_v);
      end
      n_tests++;
      if (east && west) begin
        n_fail++;
        $display("FAIL exclusive step=%0d east=%b west=%b expected not both", stepno, east, west);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Raw levels applied now are sampled by the next rising edge.
  task automatic step(input logic e, input logic w);
    east_raw = e;
    west_raw = w;
    @(posedge clk);
    #1;
    stepno++;
    model_edge(e, w);
    sb.push_back({m_east, m_west, m_pressed});
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_immediate", int'({east, west, pressed}), 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      stepno++;
      sb.push_back(3'b000);
    end
    rst_n = 1'b1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first, npe, npw, npr, last_hi, fall_at;
    bit prev_pr;
    model_reset();
    apply_reset(3);

    // Single east press: pulse exactly at edge DC+2, no west activity.
    first = -1; npe = 0; npw = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      if (east && first < 0) first = i;
      if (east) npe++;
      if (west) npw++;
    end
    check("first_east_edge", first, DC + 2);
    check("west_quiet", npw, 0);
    if (!AUTO) check("single_pulse", npe, 1);
    check("pressed_held", int'(pressed), 1);
    idle_steps(12);
    check("released", int'(pressed), 0);

    // West glitch: 3 high, 1 low, 3 high.
    npw = 0; npr = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, (i == 3) ? 1'b0 : 1'b1);
      if (west) npw++;
      if (pressed) npr++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (west) npw++;
      if (pressed) npr++;
    end
    check("glitch_no_west", npw, 0);
    check("glitch_no_pressed", npr, 0);

    // Both buttons together: nothing happens.
    npe = 0; npw = 0; npr = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      npe += int'(east); npw += int'(west); npr += int'(pressed);
    end
    idle_steps(4);
    check("both_no_pulse", npe + npw, 0);
    check("both_no_pressed", npr, 0);

    // Reset in the middle of a held east press.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    apply_reset(2);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      if (east && first < 0) first = i;
    end
    check("reset_repress_edge", first, DC + 2);
    idle_steps(12);

    // Release bounce after an accepted press.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    npe = 0; last_hi = 0; fall_at = -1; prev_pr = 1;
    for (int j = 0; j < 6; j++) begin
      step((j % 2) == 1, 1'b0);
      if ((j % 2) == 1) last_hi = stepno;
      npe += int'(east);
      if (prev_pr && !pressed && fall_at < 0) fall_at = stepno;
      prev_pr = pressed;
    end
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 1'b0);
      npe += int'(east);
      if (prev_pr && !pressed && fall_at < 0) fall_at = stepno;
      prev_pr = pressed;
    end
    check("bounce_no_pulse", npe, 0);
    // Synchronizer adds two edges before the FSM sees the last high sample.
    check("bounce_fall_delay", fall_at - last_hi, DC + 2);

    // Random phase.
    for (int seg = 0; seg < 220; seg++) begin
      int sel, len;
      logic e, w;
      sel = int'($urandom_range(0, 9));
      len = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 25));
      e = (sel <= 3) || (sel == 7);
      w = ((sel >= 4) && (sel <= 6)) || (sel == 7);
      if ($urandom_range(0, 39) == 0) apply_reset(int'($urandom_range(1, 3)));
      for (int k = 0; k < len; k++) step(e, w);
    end
    idle_steps(15);
    @(negedge clk);
    #1;
    check("queue_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog time limit reached at step=%0d", stepno);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/btn_step_gen.md
BTN_STEP_GEN -- requirements
Module: btn_step_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press or release; legal range 1..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 8: cycles from the first step pulse to the first auto-repeat pulse; legal range 1..2^20-1.
REQ-003 Parameter REPEAT_PERIOD, default 3: cycles between successive auto-repeat pulses; legal range 1..2^20-1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 east_raw  input  1  raw asynchronous east button level, 1 = pressed.
REQ-007 west_raw  input  1  raw asynchronous west button level, 1 = pressed.
REQ-008 east  output  1  registered one-cycle step pulse toward the counter's east input.
REQ-009 west  output  1  registered one-cycle step pulse toward the counter's west input.
REQ-010 pressed  output  1  registered debounced level, 1 while a press is accepted and not yet released.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 The FSM SHALL have the states IDLE, DB_PRESS, HOLD, REPEAT and DB_RELEASE, plus a 20-bit cycle counter and a 1-bit direction register.
REQ-013 IDLE: when exactly one synchronized input is high, latch the direction, clear the counter and go to DB_PRESS; when both or neither are high, stay in IDLE.
REQ-014 DB_PRESS: count cycles with the latched input high; any low sample returns the FSM to IDLE with no pulse.
REQ-015 On the DEBOUNCE_CYCLES-th consecutive high sample, pulse the latched direction output for one cycle, set pressed=1, clear the counter and go to HOLD.
REQ-016 With default parameters, a raw level held high from edge 1 SHALL produce the pulse in the cycle following rising edge 6, i.e. at edge DEBOUNCE_CYCLES+2.
REQ-017 HOLD/REPEAT: a low sample on the latched input SHALL clear the counter and move the FSM to DB_RELEASE; the opposite input is ignored.
REQ-018 DB_RELEASE: require DEBOUNCE_CYCLES consecutive samples with both inputs low before going to IDLE with pressed=0; any high sample restarts the count; no pulses are emitted in this state.
REQ-019 east and west SHALL never be high in the same cycle, and no output pulse SHALL be longer than one cycle.
REQ-020 The counter SHALL saturate and never wrap.

Reset
REQ-021 Asserting reset low SHALL asynchronously force IDLE, counter=0, direction=0, synchronizers=0, east=0, west=0 and pressed=0.
REQ-022 Reset asserted mid-press SHALL drop any pending pulse; after reset release, a still-held button SHALL be debounced again from IDLE.
REQ-023 Reset deassertion is synchronized by the system; the block SHALL leave IDLE no earlier than the third rising edge after deassertion.

Configuration
REQ-024 Macro AUTO_REPEAT_EN defined: after REPEAT_DELAY cycles in HOLD, emit one pulse and go to REPEAT; in REPEAT, emit one pulse every REPEAT_PERIOD cycles while the button is held.
REQ-025 AUTO_REPEAT_EN undefined: HOLD never transitions to REPEAT, exactly one pulse is emitted per accepted press, and the repeat parameters are unused.

Verification
REQ-026 Defaults, east_raw high from edge 1 for 20 cycles -> east high only in the cycle after edge 6; west stays 0; pressed=1 from edge 6.
REQ-027 west_raw glitches high 3 cycles, low 1 cycle, high 3 cycles -> no west pulse; pressed stays 0.
REQ-028 east_raw and west_raw rise in the same cycle and are held 10 cycles -> no pulses; FSM stays IDLE.
REQ-029 AUTO_REPEAT_EN defined, west_raw held 30 cycles -> west pulses at edges 6, 14, 17, 20, ... every 3 cycles until release; each pulse is one cycle wide.
REQ-030 east_raw held, reset pulsed low at edge 10 for 2 cycles -> all outputs 0 immediately; a new east pulse appears DEBOUNCE_CYCLES+2 edges after reset release.
REQ-031 After an accepted press, east_raw bounces low/high every cycle for 6 cycles, then stays low -> no extra pulse; pressed falls 4 cycles after the last high sample.
